// File: rtl/gpio_port_bank.sv
// Purpose: bank of NUM_PORTS registered GPIO output ports with write/set/clear/toggle,
//          a SYNC_STAGES-deep input synchroniser, readback and optional edge interrupt.
// Latency: writes visible one clk_valid edge later; input pins reach in_sync after
//          SYNC_STAGES valid edges. No backpressure: every strobe is accepted.
//
// Optional feature: define GPIO_EDGE_IRQ_EN to build the both-edge interrupt logic.
//   Without it, irq_pending and irq are tied to 0 and irq_mask/irq_ack are ignored.
//
// Ports:
//   clk, arst_n    clock (rising edge), asynchronous active-low reset
//   clk_valid      clock qualifier; all state holds while 0
//   wr_en/wr_sel/wr_mode/wr_data
//                  write strobe, target port, mode (00 wr, 01 set, 10 clr, 11 tgl), data/mask
//   rd_sel/rd_data combinational readback; out-of-range select reads 0
//   in_pins/in_sync
//                  asynchronous pins in, synchronised value out
//   out_ports      flat bus, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   sel_err        one valid-cycle pulse after an out-of-range write
//   irq, irq_mask, irq_ack, irq_pending
//                  edge interrupt, per-bit enable, write-1-to-clear, sticky flags
module gpio_port_bank #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_PORTS   = 4,   // 2..16
    parameter int SEL_WIDTH   = 2,   // 2**SEL_WIDTH >= NUM_PORTS
    parameter int SYNC_STAGES = 2    // 2..4
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic                            clk_valid,
    input  logic                            wr_en,
    input  logic [SEL_WIDTH-1:0]            wr_sel,
    input  logic [1:0]                      wr_mode,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic [SEL_WIDTH-1:0]            rd_sel,
    output logic [DATA_WIDTH-1:0]           rd_data,
    input  logic [DATA_WIDTH-1:0]           in_pins,
    output logic [DATA_WIDTH-1:0]           in_sync,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] out_ports,
    output logic                            sel_err,
    output logic                            irq,
    input  logic [DATA_WIDTH-1:0]           irq_mask,
    input  logic [DATA_WIDTH-1:0]           irq_ack,
    output logic [DATA_WIDTH-1:0]           irq_pending
);

    logic [DATA_WIDTH-1:0] port_reg [NUM_PORTS];
    logic [DATA_WIDTH-1:0] sync_q   [SYNC_STAGES];
    logic                  wr_hit;

    function automatic logic [DATA_WIDTH-1:0] apply_mode(
        input logic [1:0]            mode,
        input logic [DATA_WIDTH-1:0] cur,
        input logic [DATA_WIDTH-1:0] data
    );
        logic [DATA_WIDTH-1:0] res;
        unique case (mode)
            2'b00:   res = data;
            2'b01:   res = cur | data;
            2'b10:   res = cur & ~data;
            default: res = cur ^ data;
        endcase
        return res;
    endfunction

    // Select decode by comparison against each legal index, so a select wider than
    // the port count never indexes past the array.
    always_comb begin
        wr_hit = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (wr_sel == SEL_WIDTH'(k)) wr_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int k = 0; k < NUM_PORTS; k++) port_reg[k] <= '0;
            sel_err <= 1'b0;
        end else if (clk_valid) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (wr_en && (wr_sel == SEL_WIDTH'(k)))
                    port_reg[k] <= apply_mode(wr_mode, port_reg[k], wr_data);
            end
            // Re-evaluated every valid cycle, so the flag lasts exactly one of them.
            sel_err <= wr_en & ~wr_hit;
        end
    end

    always_comb begin
        rd_data   = '0;
        out_ports = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (rd_sel == SEL_WIDTH'(k)) rd_data = port_reg[k];
            out_ports[k*DATA_WIDTH +: DATA_WIDTH] = port_reg[k];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else if (clk_valid) begin
            sync_q[0] <= in_pins;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_EDGE_IRQ_EN
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] pending_q;

    // A fresh edge wins over an ack of the same bit in the same cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            prev_q    <= '0;
            pending_q <= '0;
        end else if (clk_valid) begin
            prev_q    <= in_sync;
            pending_q <= (pending_q & ~irq_ack) | (in_sync ^ prev_q);
        end
    end

    assign irq_pending = pending_q;
    assign irq         = |(pending_q & irq_mask);
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{irq_mask, irq_ack};
    assign irq_pending       = '0;
    assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_port_bank.sv
module tb_gpio_port_bank;
    localparam int DW = 8;
    localparam int NP = 3;
    localparam int SW = 2;
    localparam int SS = 3;

    logic             clk = 1'b0;
    logic             arst_n, clk_valid, wr_en;
    logic [SW-1:0]    wr_sel, rd_sel;
    logic [1:0]       wr_mode;
    logic [DW-1:0]    wr_data, in_pins, irq_mask, irq_ack;
    logic [DW-1:0]    rd_data, in_sync, irq_pending;
    logic [NP*DW-1:0] out_ports;
    logic             sel_err, irq;

    gpio_port_bank #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .SEL_WIDTH(SW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .arst_n(arst_n), .clk_valid(clk_valid), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_mode(wr_mode), .wr_data(wr_data), .rd_sel(rd_sel), .rd_data(rd_data),
        .in_pins(in_pins), .in_sync(in_sync), .out_ports(out_ports), .sel_err(sel_err),
        .irq(irq), .irq_mask(irq_mask), .irq_ack(irq_ack), .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: port values, error flag, history of sampled pins, irq flags.
    logic [DW-1:0] pm [NP];
    logic          se_m;
    logic [DW-1:0] pins_q [$];
    logic [DW-1:0] sync_m, prev_m, pend_m;

    function automatic logic [DW-1:0] apply(input logic [1:0] m, input logic [DW-1:0] o,
                                            input logic [DW-1:0] d);
        case (m)
            2'd0:    return d;
            2'd1:    return o | d;
            2'd2:    return o & ~d;
            default: return o ^ d;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NP; k++) pm[k] = '0;
        se_m = 1'b0;
        pins_q.delete();
        sync_m = '0;
        prev_m = '0;
        pend_m = '0;
    endtask

    task automatic model_edge();
        if (!clk_valid) return;
        se_m = wr_en && (int'(wr_sel) >= NP);
        if (wr_en && (int'(wr_sel) < NP)) pm[wr_sel] = apply(wr_mode, pm[wr_sel], wr_data);
`ifdef GPIO_EDGE_IRQ_EN
        pend_m = (pend_m & ~irq_ack) | (sync_m ^ prev_m);
        prev_m = sync_m;
`endif
        // in_sync shows the pin value sampled SS valid edges ago (0 before that).
        pins_q.push_back(in_pins);
        if (pins_q.size() > SS) void'(pins_q.pop_front());
        sync_m = (pins_q.size() == SS) ? pins_q[0] : '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NP*DW-1:0] ep;
        logic [DW-1:0]    er;
        for (int k = 0; k < NP; k++) ep[k*DW +: DW] = pm[k];
        er = (int'(rd_sel) < NP) ? pm[rd_sel] : '0;
        check({tag, "_ports"},   32'(out_ports),   32'(ep));
        check({tag, "_rd"},      32'(rd_data),     32'(er));
        check({tag, "_selerr"},  32'(sel_err),     32'(se_m));
        check({tag, "_insync"},  32'(in_sync),     32'(sync_m));
        check({tag, "_pending"}, 32'(irq_pending), 32'(pend_m));
        check({tag, "_irq"},     32'(irq),         32'(|(pend_m & irq_mask)));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic wr(input logic [SW-1:0] s, input logic [1:0] m, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_sel = s; wr_mode = m; wr_data = d;
    endtask

    initial begin
        arst_n = 1'b0; clk_valid = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_mode = '0;
        wr_data = '0; rd_sel = '0; in_pins = '0; irq_mask = '0; irq_ack = '0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1; clk_valid = 1'b1;

        // Plain write to port 2 and readback.
        rd_sel = 2'd2;
        wr(2'd2, 2'd0, 8'hA5);
        tick("wr_p2");
        check("p2_is_a5", 32'(out_ports[23:16]), 32'h A5);
        check("p0p1_zero", 32'(out_ports[15:0]), 32'h0);
        check("rd_p2", 32'(rd_data), 32'hA5);

        // Set / clear / toggle on consecutive valid cycles.
        rd_sel = 2'd1;
        wr(2'd1, 2'd0, 8'hF0); tick("p1_wr");
        wr(2'd1, 2'd1, 8'h0F); tick("p1_set");
        check("p1_set_ff", 32'(out_ports[15:8]), 32'hFF);
        wr(2'd1, 2'd2, 8'h3C); tick("p1_clr");
        check("p1_clr_c3", 32'(out_ports[15:8]), 32'hC3);
        wr(2'd1, 2'd3, 8'hFF); tick("p1_tgl");
        check("p1_tgl_3c", 32'(rd_data), 32'h3C);

        // Back-to-back toggles on port 0.
        wr(2'd0, 2'd3, 8'h01); tick("p0_tgl1");
        check("p0_tgl1_01", 32'(out_ports[7:0]), 32'h01);
        tick("p0_tgl2");
        check("p0_tgl2_00", 32'(out_ports[7:0]), 32'h00);

        // Out-of-range select.
        wr(2'd3, 2'd0, 8'h55); rd_sel = 2'd3; tick("oor");
        check("oor_selerr", 32'(sel_err), 32'h1);
        check("oor_rd_zero", 32'(rd_data), 32'h0);
        wr_en = 1'b0; tick("oor_after");
        check("oor_pulse_end", 32'(sel_err), 32'h0);

        // Qualifier low: write and pins frozen.
        clk_valid = 1'b0; in_pins = 8'h3C; wr(2'd0, 2'd0, 8'h77);
        for (int i = 0; i < 4; i++) tick("hold");
        check("hold_p0", 32'(out_ports[7:0]), 32'h00);
        check("hold_insync", 32'(in_sync), 32'h00);
        clk_valid = 1'b1; tick("release");
        check("release_p0", 32'(out_ports[7:0]), 32'h77);
        wr_en = 1'b0; in_pins = 8'h00;
        for (int i = 0; i < 4; i++) tick("settle");

        // Synchroniser latency.
        in_pins = 8'h81;
        tick("sync1"); check("sync1_0", 32'(in_sync), 32'h00);
        tick("sync2"); check("sync2_0", 32'(in_sync), 32'h00);
        tick("sync3"); check("sync3_81", 32'(in_sync), 32'h81);
        tick("sync4");

        // Mid-operation reset while pending flags may be set.
        wr(2'd1, 2'd0, 8'hEE);
        #3 arst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        check("rst_mid_pend", 32'(irq_pending), 32'h0);
        wr_en = 1'b0; in_pins = 8'h00; irq_mask = 8'h01;
        @(negedge clk);
        arst_n = 1'b1;

        // Edge interrupt on bit 0.
        in_pins = 8'h01;
        for (int i = 0; i < 3; i++) tick("irq_rise");
        check("irq_insync_01", 32'(in_sync), 32'h01);
        tick("irq_set");
`ifdef GPIO_EDGE_IRQ_EN
        check("irq_pend_01", 32'(irq_pending), 32'h01);
        check("irq_hi", 32'(irq), 32'h1);
`endif
        in_pins = 8'h00;
        for (int i = 0; i < 3; i++) tick("irq_fall");
        irq_ack = 8'h01; tick("irq_ack_vs_edge");
`ifdef GPIO_EDGE_IRQ_EN
        check("set_wins_ack", 32'(irq_pending), 32'h01);
`endif
        tick("irq_ack2");
        check("irq_cleared_pend", 32'(irq_pending), 32'h00);
        check("irq_cleared", 32'(irq), 32'h0);
        irq_ack = 8'h00;

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            clk_valid = ($urandom_range(0, 3) != 0);
            wr_en     = $urandom_range(0, 1) == 1;
            wr_sel    = SW'($urandom);
            wr_mode   = 2'($urandom);
            wr_data   = DW'($urandom);
            rd_sel    = SW'($urandom);
            if ($urandom_range(0, 3) == 0) in_pins = DW'($urandom);
            irq_mask  = DW'($urandom);
            irq_ack   = ($urandom_range(0, 3) == 0) ? DW'($urandom) : '0;
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gpio_port_bank.md
Name: gpio_port_bank

Overview:
- Parametrised successor to the single-select two-port GPIO demux used by the 8-bit uC top.
- Provides NUM_PORTS registered output ports of DATA_WIDTH bits, with four write modes (write/set/clear/toggle) and range-checked port select.
- Also provides a multi-stage synchronised input port and register readback.
- Sits between the control unit (write/read strobes) and chip pins; all state advances only on clk edges where clk_valid=1.

Parameters:
- DATA_WIDTH, 8: width of each output port, the input port and the data buses.
- NUM_PORTS, 4: number of output ports, legal range 2..16.
- SEL_WIDTH, 2: port-select width; must satisfy 2**SEL_WIDTH >= NUM_PORTS.
- SYNC_STAGES, 2: input synchroniser depth, legal range 2..4.

Ports:
- clk  in  1  system clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- clk_valid  in  1  clock qualifier; state updates only when 1.
- wr_en  in  1  write strobe.
- wr_sel  in  SEL_WIDTH  target port index.
- wr_mode  in  2  00 write, 01 set (OR), 10 clear (AND NOT), 11 toggle (XOR).
- wr_data  in  DATA_WIDTH  write data or bit mask.
- rd_sel  in  SEL_WIDTH  readback port index.
- rd_data  out  DATA_WIDTH  combinational readback of port_reg[rd_sel].
- in_pins  in  DATA_WIDTH  asynchronous input pins.
- in_sync  out  DATA_WIDTH  synchronised input value.
- out_ports  out  NUM_PORTS*DATA_WIDTH  flat output bus; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- sel_err  out  1  one-cycle pulse on an out-of-range write.
- irq  out  1  edge interrupt (see Optional Feature).
- irq_mask  in  DATA_WIDTH  per-bit interrupt enable.
- irq_ack  in  DATA_WIDTH  per-bit write-1-to-clear of pending flags.
- irq_pending  out  DATA_WIDTH  sticky edge flags.

Behaviour:
- Reset (arst_n=0, asynchronous):
  - all port_reg, synchroniser stages, the in_sync previous sample, irq_pending and sel_err clear to 0;
  - out_ports=0, in_sync=0, irq=0;
  - rd_data follows port_reg and therefore reads 0.
- Reset release: first update occurs on the first rising clk with clk_valid=1.
- Write, on rising clk with clk_valid=1, wr_en=1 and wr_sel<NUM_PORTS:
  - port_reg[wr_sel] <= f(mode, port_reg, wr_data);
  - the new value is visible on out_ports and rd_data one cycle after the strobe.
- Out-of-range write (wr_sel>=NUM_PORTS):
  - no port changes;
  - sel_err=1 for exactly one clk_valid cycle, then 0.
- clk_valid=0: every register holds, including sel_err, the synchroniser and pending flags; wr_en is ignored.
- Back-to-back writes to the same port use the updated value each cycle. Example: toggle 0x01 twice from 0x00 gives 0x01, then 0x00.
- Only one port is written per cycle; untouched ports hold.
- rd_sel>=NUM_PORTS: rd_data=0.
- Input synchroniser: SYNC_STAGES-flop chain per bit, shifting on each clk_valid cycle. A pin change appears on in_sync after exactly SYNC_STAGES valid cycles.
- Mid-operation reset: aborts any write in progress and clears all state immediately; no pending or sel_err survives.

Optional Feature:
- Macro: GPIO_EDGE_IRQ_EN.
- Defined:
  - the block keeps prev = in_sync, delayed one valid cycle;
  - edge = in_sync ^ prev (both edges);
  - irq_pending <= (irq_pending & ~irq_ack) | edge, so set wins over ack on the same bit in the same cycle;
  - irq = |(irq_pending & irq_mask), registered-free combinational from irq_pending;
  - pending flags set regardless of irq_mask.
- Not defined: irq_pending=0 and irq=0 constantly; irq_mask and irq_ack are ignored; no edge logic is generated.

Test Plan:
- Reset, then write mode 00, sel 2, data 0xA5 -> next cycle out_ports[23:16]=0xA5; other ports 0x00; rd_sel=2 gives rd_data=0xA5.
- Port 1 = 0xF0:
  - set 0x0F -> 0xFF;
  - clear 0x3C -> 0xC3;
  - toggle 0xFF -> 0x3C, on consecutive valid cycles.
- NUM_PORTS=3, write sel 3 data 0x55 -> all ports unchanged; sel_err high exactly one cycle.
- Write held with clk_valid=0 for 4 cycles -> no change, and in_sync frozen. Raise clk_valid -> write takes effect next edge.
- in_pins 0x00 -> 0x81 with SYNC_STAGES=3 -> in_sync=0x81 after exactly 3 valid cycles.
- GPIO_EDGE_IRQ_EN, irq_mask=0x01:
  - bit0 rises -> irq_pending=0x01 and irq=1;
  - irq_ack=0x01 together with a new bit0 fall -> pending stays 0x01;
  - the next irq_ack=0x01 -> pending=0, irq=0;
  - assert arst_n=0 while pending -> all cleared.
